// File: rtl/uart_tx_core.sv
// Generic synchronous FIFO: registered pointers, occupancy counter, head word visible combinationally.
// Latency: a pushed word is at the head one clock after the push when the FIFO was empty.
// Backpressure: a push while full or a pop while empty is ignored; full/empty flag it to the caller.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_vld,
  input  logic [W-1:0]                   push_dat,
  input  logic                           pop,
  output logic [W-1:0]                   head_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_q];
  assign count    = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_dat;
  end
endmodule

// UART transmitter: FIFO-buffered words framed as START, DATA (LSB first), optional PARITY, 1-2 STOP.
// Latency: txo falls one clock after a word is accepted into an empty, idle block.
// Backpressure: din_ready drops while the FIFO holds FIFO_DEPTH words; frames run back to back.
module uart_tx_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2:0]                        bc,
  input  logic [1:0]                        par_mode,
  input  logic                              stop2,
  input  logic [DATA_W-1:0]                 din,
  input  logic                              din_valid,
  output logic                              din_ready,
  output logic                              txo,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int DIV_9600   = CLK_HZ / 9600;
  localparam int DIV_19200  = CLK_HZ / 19200;
  localparam int DIV_38400  = CLK_HZ / 38400;
  localparam int DIV_57600  = CLK_HZ / 57600;
  localparam int DIV_115200 = CLK_HZ / 115200;
  localparam int CW  = $clog2(DIV_9600 + 1);
  localparam int IW  = $clog2(DATA_W + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, div_q, div_d, div_sel;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d, head;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic              txo_q, txo_d;
  logic              rdy_en_q;
  logic              pop, load, bit_end, fifo_full, fifo_empty;
  logic [FCW-1:0]    cnt_fifo;

  // Held low through reset, enabled from the first clock edge afterwards.
  assign din_ready  = rdy_en_q && !fifo_full;
  assign fifo_count = cnt_fifo;
  assign busy       = (state_q != S_IDLE);
  assign txo        = txo_q;
  assign bit_end    = (cnt_q == div_q - CW'(1));

  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (din_valid && din_ready),
    .push_dat (din),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (cnt_fifo)
  );

  always_comb begin
    case (bc)
      3'd1:    div_sel = CW'(DIV_19200);
      3'd2:    div_sel = CW'(DIV_38400);
      3'd3:    div_sel = CW'(DIV_57600);
      3'd4:    div_sel = CW'(DIV_115200);
      default: div_sel = CW'(DIV_9600);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (idx_q == IW'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && idx_q == '0) begin
            idx_d = IW'(1);
          end else begin
            idx_d = '0;
            if (!fifo_empty) load = 1'b1;
            else             state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Frame start: configuration is frozen here for the whole frame.
    if (load) begin
      state_d   = S_START;
      cnt_d     = '0;
      idx_d     = '0;
      sh_d      = head;
      div_d     = div_sel;
      par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
      par_bit_d = (^head) ^ (par_mode == 2'b10);
      stop2_d   = stop2;
    end
  end

  assign pop = load;

  // Output is registered from next-state values so the pin never glitches.
  always_comb begin
    case (state_d)
      S_START:  txo_d = 1'b0;
      S_DATA:   txo_d = sh_d[0];
      S_PARITY: txo_d = par_bit_d;
      default:  txo_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      div_q     <= CW'(DIV_9600);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txo_q     <= 1'b1;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      txo_q     <= txo_d;
      rdy_en_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: one 50 MHz instance for real divisors, two scaled-clock
// instances (8-bit/16-deep and 7-bit/4-deep) for multi-frame sequences.
module tb_uart_tx_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 50 MHz instance
  logic [2:0] bc_a;
  logic [1:0] par_a;
  logic       stop2_a, vld_a, rdy_a, txo_a, busy_a;
  logic [7:0] din_a;
  logic [4:0] cnt_a;

  // Scaled instances: 1.152 MHz clock gives DIV 120/60/30/20/10
  logic [2:0] bc_s;
  logic [1:0] par_s;
  logic       stop2_s;
  logic [7:0] din_b;
  logic       vld_b, rdy_b, txo_b, busy_b;
  logic [4:0] cnt_b;
  logic [6:0] din_c;
  logic       vld_c, rdy_c, txo_c, busy_c;
  logic [2:0] cnt_c;

  logic mux_sel;
  logic mbusy, mtxo;
  assign mbusy = mux_sel ? busy_c : busy_b;
  assign mtxo  = mux_sel ? txo_c  : txo_b;

  uart_tx_core dut_a (
    .clk(clk), .rst(rst), .bc(bc_a), .par_mode(par_a), .stop2(stop2_a),
    .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .txo(txo_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx_core #(.CLK_HZ(1_152_000), .DATA_W(8), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .bc(bc_s), .par_mode(par_s), .stop2(stop2_s),
    .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .txo(txo_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  uart_tx_core #(.CLK_HZ(1_152_000), .DATA_W(7), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .bc(bc_s), .par_mode(par_s), .stop2(stop2_s),
    .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
    .txo(txo_c), .busy(busy_c), .fifo_count(cnt_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one word into an idle scaled instance at bc=4 (DIV=10), then sample
  // the line mid-bit for 12 bit slots and count busy cycles.
  task automatic send_frame(input logic sel, input logic [7:0] w, input logic [1:0] pm,
                            input logic s2, input int div,
                            output int nbusy, output logic [11:0] bits);
    @(negedge clk);
    mux_sel = sel;
    bc_s    = 3'd4;
    par_s   = pm;
    stop2_s = s2;
    if (sel) begin din_c = w[6:0]; vld_c = 1'b1; end
    else     begin din_b = w;      vld_b = 1'b1; end
    @(negedge clk);
    vld_b = 1'b0;
    vld_c = 1'b0;
    nbusy = 0;
    bits  = '1;
    for (int i = 0; i < 14 * div; i++) begin
      @(negedge clk);
      if (mbusy) nbusy++;
      if ((i % div) == (div / 2) && (i / div) < 12) bits[i / div] = mtxo;
    end
  endtask

  initial begin
    int          nb, sent, j, nr, len;
    logic [11:0] bits;
    logic [9:0]  fbits;
    logic [7:0]  wexp [17];
    int          runs [4];
    logic        xfer, first_full, low_seen, rose, cur, lowseen;

    rst = 1'b1;
    bc_a = 3'd4; par_a = 2'b00; stop2_a = 1'b0; din_a = '0; vld_a = 1'b0;
    bc_s = 3'd4; par_s = 2'b00; stop2_s = 1'b0;
    din_b = '0; vld_b = 1'b0; din_c = '0; vld_c = 1'b0; mux_sel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txo", txo_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_rdy", rdy_a, 0);
    check("rst_rdy_c", rdy_c, 0);
    rst = 1'b0;
    check("rdy_before_edge", rdy_a, 0);
    @(negedge clk);
    check("rdy_after_edge", rdy_a, 1);

    // 8N1 at 115200 from 50 MHz, word 0x55
    din_a = 8'h55; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    check("a_cnt_after_push", cnt_a, 1);
    check("a_txo_idle", txo_a, 1);
    @(negedge clk);
    check("a_txo_start", txo_a, 0);
    check("a_busy_start", busy_a, 1);
    check("a_cnt_after_pop", cnt_a, 0);
    nb = 0;
    for (int i = 0; i < 4400; i++) begin
      if (busy_a) nb++;
      if ((i % 434) == 217 && (i / 434) < 10)
        check($sformatf("a_bit%0d", i / 434), txo_a, (i / 434) % 2);
      @(negedge clk);
    end
    check("a_busy_len", nb, 4340);
    check("a_txo_end", txo_a, 1);

    // Parity and stop-bit variants on 0x07
    send_frame(1'b0, 8'h07, 2'b01, 1'b0, 10, nb, bits);
    check("even_len", nb, 110);
    check("even_bits", bits, 12'hE0E);
    send_frame(1'b0, 8'h07, 2'b10, 1'b0, 10, nb, bits);
    check("odd_len", nb, 110);
    check("odd_bits", bits, 12'hC0E);
    send_frame(1'b0, 8'h07, 2'b01, 1'b1, 10, nb, bits);
    check("even_s2_len", nb, 120);
    check("even_s2_bits", bits, 12'hE0E);

    // 17 words with din_valid held: fill, backpressure, back-to-back order
    for (int k = 0; k < 17; k++) wexp[k] = 8'(k * 29 + 7);
    @(negedge clk);
    bc_s = 3'd4; par_s = 2'b00; stop2_s = 1'b0;
    sent = 0; din_b = wexp[0]; vld_b = 1'b1;
    xfer = vld_b && rdy_b;
    first_full = 1'b1; low_seen = 1'b0; rose = 1'b0; nb = 0; fbits = '0;
    for (int i = 1; i < 1760; i++) begin
      @(negedge clk);
      if (xfer) begin
        sent++;
        if (sent == 17) vld_b = 1'b0;
        else            din_b = wexp[sent];
      end
      xfer = vld_b && rdy_b;
      if (!rdy_b && first_full) begin
        check("full_cnt", cnt_b, 16);
        first_full = 1'b0;
        low_seen   = 1'b1;
      end
      if (rdy_b && low_seen && !rose) begin
        rose = 1'b1;
        check("rdy_rise_cycle", i, 102);
        check("rdy_rise_cnt", cnt_b, 15);
      end
      j = i - 2;
      if (j >= 0 && j < 1700) begin
        if (busy_b) nb++;
        if ((j % 10) == 5) fbits[(j % 100) / 10] = txo_b;
        if ((j % 100) == 95)
          check($sformatf("fifo_frame%0d", j / 100), fbits, {1'b1, wexp[j / 100], 1'b0});
      end
      if (j == 1700) check("fifo_busy_end", busy_b, 0);
    end
    check("fifo_busy_len", nb, 1700);
    check("fifo_sent", sent, 17);
    check("fifo_ready_seen", rose, 1);

    // Baud change mid-frame: first frame stays at DIV 10, second uses DIV 120
    @(negedge clk);
    bc_s = 3'd4; din_b = 8'h00; vld_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vld_b = 1'b0;
    cur = txo_b; len = 0; nr = 0; nb = 0;
    for (int i = 0; i < 1400; i++) begin
      if (i == 30) bc_s = 3'd0;
      if (busy_b) begin
        nb++;
        if (txo_b == cur) len++;
        else begin
          if (nr < 4) runs[nr] = len;
          nr++;
          cur = txo_b;
          len = 1;
        end
      end
      @(negedge clk);
    end
    if (nr < 4) runs[nr] = len;
    nr++;
    check("bc_nruns", nr, 4);
    check("bc_low1", runs[0], 90);
    check("bc_stop1", runs[1], 10);
    check("bc_low2", runs[2], 1080);
    check("bc_stop2", runs[3], 120);
    check("bc_busy_len", nb, 1300);

    // Reset in the DATA state of the second of three queued words
    @(negedge clk);
    bc_s = 3'd4; din_b = 8'hFF; vld_b = 1'b1;
    @(negedge clk);
    din_b = 8'h00;
    @(negedge clk);
    din_b = 8'hFF;
    @(negedge clk);
    vld_b = 1'b0;
    repeat (139) @(negedge clk);
    check("pre_rst_txo", txo_b, 0);
    check("pre_rst_busy", busy_b, 1);
    check("pre_rst_cnt", cnt_b, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_txo", txo_b, 1);
    check("rst_mid_busy", busy_b, 0);
    check("rst_mid_cnt", cnt_b, 0);
    check("rst_mid_rdy", rdy_b, 0);
    @(negedge clk);
    rst = 1'b0;
    nb = 0; lowseen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_b) nb++;
      if (!txo_b) lowseen = 1'b1;
    end
    check("post_rst_busy", nb, 0);
    check("post_rst_txo_low", lowseen, 0);
    check("post_rst_cnt", cnt_b, 0);

    // 7-bit data, even parity, 0x7F
    send_frame(1'b1, 8'h7F, 2'b01, 1'b0, 10, nb, bits);
    check("w7_len", nb, 100);
    check("w7_bits", bits, 12'hFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmit engine with a built-in TX FIFO and a valid/ready input handshake. It replaces the fixed 8-bit, baud-select-only transmitter path. It adds configurable data width, runtime parity mode (none/even/odd), one or two stop bits, and buffering of up to FIFO_DEPTH words. It sits between the user/data source and the serial TX pin, with baud generation internal to the block.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz; used to derive baud divisors.
- DATA_W, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16: TX FIFO entries; power of two, ≥2.

- clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  reset, asynchronous, active-high.
- bc  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- par_mode  in  2  00=none, 01=even, 10=odd, 11=none.
- stop2  in  1  1 = two stop bits, 0 = one stop bit.
- din  in  DATA_W  word to transmit.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  FIFO can accept a word; transfer on valid&ready at rising clk.
- txo  out  1  serial output; idle high.
- busy  out  1  high while any frame bit is on txo, from START through STOP.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently buffered.

## Operation
- Divisor DIV = floor(CLK_HZ / baud). At 50 MHz this gives 5208/2604/1302/868/434. Every frame bit lasts exactly DIV clocks.
- bc, par_mode and stop2 are sampled once, on the cycle a frame starts, and held for the whole frame. Changes mid-frame have no effect until the next frame.
- FIFO behaviour:
  - din_ready = (fifo_count < FIFO_DEPTH).
  - A push when full is impossible by construction.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txo=1, busy=0. If FIFO is non-empty, pop the head into the shift register, latch config, and go to START.
  - START: txo=0 for DIV clocks, then go to DATA.
  - DATA: shift out DATA_W bits LSB first, DIV clocks each. Then go to PARITY if par_mode is 01/10, else STOP.
  - PARITY: txo = XOR of data bits (even) or its inverse (odd), for DIV clocks. Then go to STOP.
  - STOP: txo=1 for DIV clocks (stop2=0) or 2·DIV clocks (stop2=1). On the last stop clock, if the FIFO is non-empty, pop, latch config and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit-period counter and bit index reset to 0 at every state entry. No fractional baud correction.
- Frame length = (1 + DATA_W + P + S)·DIV clocks, where P ∈ {0,1} and S ∈ {1,2}.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - txo=1, busy=0, fifo_count=0, din_ready=0.
  - FSM=IDLE; FIFO pointers cleared.
- First clock edge after rst deasserts: din_ready=1.
- Reset mid-frame aborts the frame immediately. txo returns high without waiting for a clock. FIFO contents are discarded.
- Latency from an idle block: word accepted at edge E0 → fifo_count=1 after E0 → IDLE pops at E1 → txo=0 and busy=1 after E1. txo falls 1 clock after acceptance, measured edge to edge.
- The pop at a frame start frees a FIFO slot. din_ready rises in the clock after the pop if the FIFO was full.
- busy falls in the same cycle the FSM enters IDLE. Back-to-back frames keep busy high continuously.

## Test plan
- Reset, 8N1, bc=4, push 0x55 → txo low 1 clock after acceptance. Bits sampled every 434 clocks read 0,1,0,1,0,1,0,1,0,1. busy high for exactly 4340 clocks.
- par_mode=01, then 10, push 0x07 → parity bit 1 (even), then 0 (odd). Frame = 11·DIV clocks; stop2=1 extends it to 12·DIV.
- Hold din_valid high while txo is busy, 17 words, FIFO_DEPTH=16:
  - din_ready drops at fifo_count=16 and rises one clock after the next pop.
  - All words are transmitted in order with no idle gap between frames.
- Change bc from 4 to 0 mid-frame → current frame completes at DIV=434. The next frame uses DIV=5208.
- Assert rst midway through the DATA state of the 2nd of 3 queued words:
  - txo=1 immediately; fifo_count=0; busy=0.
  - No further frames are sent after release.
- DATA_W=7, push 0x7F → 7 data bits, all 1. Then parity (even → 1) and stop bits, with frame length (1+7+1+1)·DIV.
